// File: rtl/ps2_paddle_ctrl.sv
// ps2_paddle_ctrl: buffers decoded PS/2 key events, tracks the eight paddle
// keys and issues per-paddle move strobes (immediate on press, auto-repeat
// on a shared tick while exactly one direction of a paddle is held).
module ps2_paddle_ctrl #(
    parameter int REPEAT_DIV = 500000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ev_valid_i,
    input  logic [9:0] ev_code_i,
    output logic [3:0] paddle_up_o,
    output logic [3:0] paddle_dn_o,
    output logic [7:0] key_state_o,
    output logic       fifo_ovf_o,
    input  logic       ovf_clr_i
);
    localparam int            PW        = $clog2(FIFO_DEPTH);
    localparam int            TW        = $clog2(REPEAT_DIV);
    localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TICK_LAST = TW'(REPEAT_DIV - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, APPLY = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          full, empty, push, pop, apply_en;
    logic [9:0]    ev_q, ev_d;
    logic [3:0]    hit;
    logic [7:0]    key_q, key_d, key_prev_q, press;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic [3:0]    up_q, up_d, dn_q, dn_d;
    logic          ovf_q, ovf_d;

    // Returns {hit, key index}; the extended-prefix bit must match exactly.
    function automatic logic [3:0] map_key(input logic [9:0] code);
        logic [3:0] r;
        case ({code[9], code[7:0]})
            9'h01D:  r = 4'b1_000;  // W        P0 up
            9'h01B:  r = 4'b1_001;  // S        P0 down
            9'h175:  r = 4'b1_010;  // arrow up P1 up
            9'h172:  r = 4'b1_011;  // arrow dn P1 down
            9'h043:  r = 4'b1_100;  // I        P2 up
            9'h042:  r = 4'b1_101;  // K        P2 down
            9'h075:  r = 4'b1_110;  // keypad 8 P3 up
            9'h072:  r = 4'b1_111;  // keypad 2 P3 down
            default: r = 4'b0_000;
        endcase
        return r;
    endfunction

    // FIFO control: full is judged before a same-cycle pop, so a full FIFO
    // drops the incoming event even while the FSM is draining it.
    always_comb begin
        full     = (count_q == DEPTH_C);
        empty    = (count_q == '0);
        push     = ev_valid_i & ~full;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ev_code_i;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: one event per IDLE/FETCH/APPLY round.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = FETCH;
            FETCH:   state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        pop      = (state_q == FETCH);
        apply_en = (state_q == APPLY);
    end

    // Event register load, key-state update and move-strobe scheduling.
    always_comb begin
        ev_d  = pop ? mem_q[rd_ptr_q] : ev_q;
        hit   = map_key(ev_q);
        key_d = key_q;
        // Typematic makes and stray breaks rewrite the bit to its current value.
        if (apply_en && hit[3]) key_d[hit[2:0]] = ~ev_q[8];

        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

        // A press edge and a tick in the same cycle merge into one strobe;
        // a held conflicting pair suppresses both directions.
        press = key_q & ~key_prev_q;
        for (int p = 0; p < 4; p++) begin
            up_d[p] = key_q[2*p]   & ~key_q[2*p+1] & (press[2*p]   | tick);
            dn_d[p] = key_q[2*p+1] & ~key_q[2*p]   & (press[2*p+1] | tick);
        end

        if (ovf_clr_i)                ovf_d = 1'b0;
        else if (ev_valid_i && full)  ovf_d = 1'b1;
        else                          ovf_d = ovf_q;
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_q       <= '0;
            key_q      <= '0;
            key_prev_q <= '0;
            tick_cnt_q <= '0;
            up_q       <= '0;
            dn_q       <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ev_q       <= ev_d;
            key_q      <= key_d;
            key_prev_q <= key_q;
            tick_cnt_q <= tick_cnt_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
            ovf_q      <= ovf_d;
        end
    end

    assign paddle_up_o = up_q;
    assign paddle_dn_o = dn_q;
    assign key_state_o = key_q;
    assign fifo_ovf_o  = ovf_q;

endmodule

// File: tb/tb_ps2_paddle_ctrl.sv
// Bench for ps2_paddle_ctrl: event-timing model (apply edge = max(push+3,
// previous apply+3)) plus directed scenarios with literal expectations.
module tb_ps2_paddle_ctrl;
    localparam int DIV   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ev_valid = 1'b0;
    logic [9:0] ev_code  = '0;
    logic       ovf_clr  = 1'b0;
    logic [3:0] paddle_up, paddle_dn;
    logic [7:0] key_state;
    logic       fifo_ovf;

    ps2_paddle_ctrl #(.REPEAT_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .ev_valid_i  (ev_valid),
        .ev_code_i   (ev_code),
        .paddle_up_o (paddle_up),
        .paddle_dn_o (paddle_dn),
        .key_state_o (key_state),
        .fifo_ovf_o  (fifo_ovf),
        .ovf_clr_i   (ovf_clr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int up_cnt = 0;
    int dn_cnt = 0;

    // ---------------- behavioural model ----------------
    int         cyc = 0;
    int         last_a = -100;
    logic [7:0] mk = '0, mk_prev = '0;
    logic [3:0] mup = '0, mdn = '0;
    logic       movf = 1'b0;
    int         qa[$];
    logic [9:0] qc[$];

    function automatic int map_idx(input logic [9:0] c);
        case ({c[9], c[7:0]})
            9'h01D: return 0;
            9'h01B: return 1;
            9'h175: return 2;
            9'h172: return 3;
            9'h043: return 4;
            9'h042: return 5;
            9'h075: return 6;
            9'h072: return 7;
            default: return -1;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; last_a = -100; mk = '0; mk_prev = '0;
            mup = '0; mdn = '0; movf = 1'b0;
            qa.delete(); qc.delete();
        end else begin : mdl
            bit tk, dropped;
            int e, a, k;
            tk = ((cyc % DIV) == DIV - 1);
            for (int p = 0; p < 4; p++) begin
                mup[p] = mk[2*p] && !mk[2*p+1] && ((mk[2*p] && !mk_prev[2*p]) || tk);
                mdn[p] = mk[2*p+1] && !mk[2*p] && ((mk[2*p+1] && !mk_prev[2*p+1]) || tk);
            end
            mk_prev = mk;
            cyc++;
            e = cyc;
            while (qa.size() > 0 && qa[0] == e) begin
                k = map_idx(qc[0]);
                if (k >= 0) mk[k] = !qc[0][8];
                void'(qa.pop_front());
                void'(qc.pop_front());
            end
            dropped = 1'b0;
            if (ev_valid) begin
                if (qa.size() < DEPTH) begin
                    a = (e + 3 > last_a + 3) ? e + 3 : last_a + 3;
                    qa.push_back(a);
                    qc.push_back(ev_code);
                    last_a = a;
                end else begin
                    dropped = 1'b1;
                end
            end
            if (ovf_clr)      movf = 1'b0;
            else if (dropped) movf = 1'b1;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic step();
        @(negedge clk);
        if (!rst) begin
            chk("key_state", 32'(key_state), 32'(mk));
            chk("paddle_up", 32'(paddle_up), 32'(mup));
            chk("paddle_dn", 32'(paddle_dn), 32'(mdn));
            chk("fifo_ovf",  32'(fifo_ovf),  32'(movf));
        end
        up_cnt += int'(paddle_up[0]);
        dn_cnt += int'(paddle_dn[0]);
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [9:0] c);
        ev_valid = 1'b1;
        ev_code  = c;
        step();
        ev_valid = 1'b0;
    endtask

    int u0, d0;
    logic [9:0] burst5 [6] = '{10'h01D, 10'h01B, 10'h11D, 10'h043, 10'h042, 10'h075};
    logic [9:0] burst6 [4] = '{10'h01B, 10'h042, 10'h275, 10'h072};

    initial begin
        wait_n(3);
        chk("reset_key", 32'(key_state), 32'h0);
        chk("reset_up",  32'(paddle_up), 32'h0);
        chk("reset_dn",  32'(paddle_dn), 32'h0);
        chk("reset_ovf", 32'(fifo_ovf),  32'h0);
        rst = 1'b0;

        // 1: press W, latency to key_state and single immediate strobe
        send(10'h01D);
        wait_n(2);
        chk("lat_before", 32'(key_state), 32'h00);
        step();
        chk("lat_key",    32'(key_state), 32'h01);
        chk("lat_noup",   32'(paddle_up), 32'h0);
        step();
        chk("press_up",   32'(paddle_up), 32'h1);
        step();
        chk("press_once", 32'(paddle_up), 32'h0);

        // 2: hold W through ticks at edges 16/32/48, then release
        wait_n(44);
        send(10'h11D);
        wait_n(40);
        chk("hold_strobes", 32'(up_cnt), 32'd4);
        chk("hold_release", 32'(key_state), 32'h00);

        // 3: ext prefix selects P1 vs P3; unmapped code ignored
        send(10'h275); wait_n(3);
        chk("ext_p1", 32'(key_state), 32'h04);
        send(10'h375); wait_n(3);
        send(10'h075); wait_n(3);
        chk("noext_p3", 32'(key_state), 32'h40);
        send(10'h01C); wait_n(3);
        chk("unmapped", 32'(key_state), 32'h40);
        send(10'h175); wait_n(3);
        chk("p3_break", 32'(key_state), 32'h00);

        // 4: conflicting pair suppresses strobes; release of S repeats W on tick
        send(10'h01D); wait_n(3);
        send(10'h01B); wait_n(3);
        chk("conflict_key", 32'(key_state), 32'h03);
        u0 = up_cnt; d0 = dn_cnt;
        wait_n(40);
        chk("conflict_up", 32'(up_cnt), 32'(u0));
        chk("conflict_dn", 32'(dn_cnt), 32'(d0));
        send(10'h11B); wait_n(3);
        u0 = up_cnt;
        wait_n(16);
        chk("resume_up", 32'(up_cnt), 32'(u0 + 1));
        chk("resume_dn", 32'(dn_cnt), 32'(d0));
        send(10'h11D); wait_n(3);

        // 5: six back-to-back events: last one dropped, overflow sticky
        for (int i = 0; i < 6; i++) begin
            ev_valid = 1'b1;
            ev_code  = burst5[i];
            step();
        end
        ev_valid = 1'b0;
        chk("ovf_set", 32'(fifo_ovf), 32'h1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(fifo_ovf), 32'h0);
        wait_n(20);
        chk("burst_keys", 32'(key_state), 32'h32);
        send(10'h11B); send(10'h142); send(10'h143);
        wait_n(12);
        chk("burst_clear", 32'(key_state), 32'h00);

        // 6: reset with two keys held and three entries in the FIFO
        send(10'h01D); send(10'h043);
        wait_n(8);
        chk("pre_rst_key", 32'(key_state), 32'h11);
        for (int i = 0; i < 4; i++) begin
            ev_valid = 1'b1;
            ev_code  = burst6[i];
            step();
        end
        ev_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_key", 32'(key_state), 32'h0);
        chk("rst_up",  32'(paddle_up), 32'h0);
        chk("rst_dn",  32'(paddle_dn), 32'h0);
        chk("rst_ovf", 32'(fifo_ovf),  32'h0);
        wait_n(2);
        rst = 1'b0;
        u0 = up_cnt; d0 = dn_cnt;
        wait_n(30);
        chk("post_rst_key", 32'(key_state), 32'h0);
        chk("post_rst_up",  32'(up_cnt), 32'(u0));
        chk("post_rst_dn",  32'(dn_cnt), 32'(d0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
